// File: rtl/sim_dpram.sv
// Dual-port, byte-writable simulation RAM with selectable read latency and write mode.
// Also flags same-index write collisions and out-of-range accesses, and echoes tohost writes.
module sim_dpram #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH_LOG2   = 16,
    parameter int unsigned ADDR_SHIFT   = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_MODE   = 0,
    parameter int unsigned TOHOST_IDX   = 49153
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    ENA,
    input  logic                    ENB,
    input  logic [DATA_WIDTH/8-1:0] WEA,
    input  logic [DATA_WIDTH/8-1:0] WEB,
    input  logic [31:0]             ADDRA,
    input  logic [31:0]             ADDRB,
    input  logic [DATA_WIDTH-1:0]   DIA,
    input  logic [DATA_WIDTH-1:0]   DIB,
    input  logic                    REGCEA,
    input  logic                    REGCEB,
    output logic [DATA_WIDTH-1:0]   DOA,
    output logic [DATA_WIDTH-1:0]   DOB,
    output logic                    VALIDA,
    output logic                    VALIDB,
    output logic                    COLL,
    output logic                    OORA,
    output logic                    OORB
);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic [31:0]           idx   [2];
    logic [DEPTH_LOG2-1:0] wa    [2];
    logic [NB-1:0]         we    [2];
    logic [DATA_WIDTH-1:0] di    [2];
    logic [DATA_WIDTH-1:0] old_w [2];
    logic [DATA_WIDTH-1:0] new_w [2];
    logic [1:0]            en;
    logic [1:0]            regce;
    logic [1:0]            in_rng;
    logic [1:0]            wr;
    logic [1:0]            rd_req;
    logic                  same;

    logic [DATA_WIDTH-1:0] s1_q [2];
    logic [DATA_WIDTH-1:0] s1_d [2];
    logic [DATA_WIDTH-1:0] do_q [2];
    logic [DATA_WIDTH-1:0] do_d [2];
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            valid_q, valid_d;
    logic [1:0]            oor_q, oor_d;
    logic                  coll_q, coll_d;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] data,
        input logic [NB-1:0]         lanes
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        for (int b = 0; b < int'(NB); b++) begin
            if (lanes[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    always_comb begin
        en    = {ENB, ENA};
        regce = {REGCEB, REGCEA};
        we[0] = WEA;
        we[1] = WEB;
        di[0] = DIA;
        di[1] = DIB;
        idx[0] = ADDRA >> ADDR_SHIFT;
        idx[1] = ADDRB >> ADDR_SHIFT;
        for (int p = 0; p < 2; p++) begin
            in_rng[p] = (idx[p] >> DEPTH_LOG2) == '0;
            wa[p]     = idx[p][DEPTH_LOG2-1:0];
            wr[p]     = en[p] && in_rng[p] && (we[p] != '0);
            old_w[p]  = mem_q[wa[p]];
        end
        same = (wa[0] == wa[1]);
        // Both ports apply lanes in A-then-B order so port B wins overlapping lanes.
        new_w[0] = merge(merge(old_w[0], di[0], wr[0] ? we[0] : '0),
                         di[1], (wr[1] && same) ? we[1] : '0);
        new_w[1] = merge(merge(old_w[1], di[0], (wr[0] && same) ? we[0] : '0),
                         di[1], wr[1] ? we[1] : '0);

        coll_d = wr[0] && wr[1] && same;
        for (int p = 0; p < 2; p++) begin
            s1_d[p]    = s1_q[p];
            do_d[p]    = do_q[p];
            pend_d[p]  = 1'b0;
            valid_d[p] = 1'b0;
            oor_d[p]   = oor_q[p] | (en[p] & ~in_rng[p]);
            rd_req[p]  = en[p] && ((we[p] == '0) || (WRITE_MODE != 2));
            if (en[p]) begin
                if (!in_rng[p]) begin
                    s1_d[p] = '0;
                end else if ((we[p] == '0) || (WRITE_MODE == 0)) begin
                    s1_d[p] = old_w[p];
                end else if (WRITE_MODE == 1) begin
                    s1_d[p] = new_w[p];
                end
            end
            if (READ_LATENCY == 2) begin
                pend_d[p]  = rd_req[p];
                valid_d[p] = pend_q[p] & regce[p];
                if (regce[p]) do_d[p] = s1_q[p];
            end else begin
                valid_d[p] = rd_req[p];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= '{default: '0};
            do_q    <= '{default: '0};
            pend_q  <= '0;
            valid_q <= '0;
            oor_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            do_q    <= do_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            oor_q   <= oor_d;
            coll_q  <= coll_d;
        end
    end

    // Memory is never reset, so writes in a reset cycle still land.
    always_ff @(posedge CLK) begin
        if (wr[0]) mem_q[wa[0]] <= new_w[0];
        if (wr[1]) mem_q[wa[1]] <= new_w[1];
    end

    always_ff @(posedge CLK) begin
        if (ENA && WEA[0] && (idx[0] == 32'(TOHOST_IDX))) $write("%c", DIA[7:0]);
    end

    assign DOA    = (READ_LATENCY == 2) ? do_q[0] : s1_q[0];
    assign DOB    = (READ_LATENCY == 2) ? do_q[1] : s1_q[1];
    assign VALIDA = valid_q[0];
    assign VALIDB = valid_q[1];
    assign COLL   = coll_q;
    assign OORA   = oor_q[0];
    assign OORB   = oor_q[1];
endmodule
